// File: rtl/dense_layer_pkg.sv
// ============================================================================
// nn_pkg : shared types and fixed-point helpers for the dense_layer block
// Revision: 1.0
// ============================================================================
`default_nettype none

package nn_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MAC    = 3'd1,
    WRITE  = 3'd2,
    MAXSUB = 3'd3,
    FINISH = 3'd4
  } dense_state_t;

  // Widest intermediate handed to sat_width; must cover any ACC_W in use.
  localparam int SAT_W = 64;

  function automatic int acc_w(input int width, input int dim);
    return 2 * width + $clog2(dim) + 1;
  endfunction

  // Clamp a sign-extended value to the signed range of a width-bit word.
  function automatic logic signed [SAT_W-1:0] sat_width(input logic signed [SAT_W-1:0] v,
                                                        input int width);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dense_layer_if.sv
// ============================================================================
// dense_layer_if : start/busy/done handshake plus operand and logit buses
// Revision: 1.0
// ============================================================================
`default_nettype none

interface dense_layer_if #(
  parameter int WIDTH   = 16,
  parameter int IN_DIM  = 16,
  parameter int OUT_DIM = 10
);
  logic                    start;
  logic signed [WIDTH-1:0] input_data  [IN_DIM];
  logic signed [WIDTH-1:0] weights     [OUT_DIM][IN_DIM];
  logic signed [WIDTH-1:0] bias        [OUT_DIM];
  logic signed [WIDTH-1:0] output_data [OUT_DIM];
  logic                    busy;
  logic                    done;

  modport master (output start, input_data, weights, bias,
                  input  output_data, busy, done);
  modport slave  (input  start, input_data, weights, bias,
                  output output_data, busy, done);
endinterface

`default_nettype wire

// File: rtl/dense_layer_mac.sv
// ============================================================================
// dense_mac : registered signed multiply-accumulate with clear and enable
// Revision: 1.0
// ============================================================================
`default_nettype none

module dense_mac #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 37
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  output logic signed [ACC_W-1:0] acc_o
);
  localparam int PW = 2 * WIDTH;

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;

  assign prod = PW'(a_i) * PW'(b_i);

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

`default_nettype wire

// File: rtl/dense_layer.sv
// ============================================================================
// dense_layer : serial fixed-point fully-connected layer, one MAC per clock.
// Optional max-subtraction of the logits enabled by macro DENSE_MAX_SUB_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dense_layer
  import nn_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int FBITS   = 8,
  parameter int IN_DIM  = 16,
  parameter int OUT_DIM = 10
) (
  input  logic         clk,
  input  logic         reset,
  dense_layer_if.slave bus
);
  localparam int ACC_W = acc_w(WIDTH, IN_DIM);
  localparam int KW    = $clog2(IN_DIM) + 1;
  localparam int JW    = $clog2(OUT_DIM) + 1;
  localparam int KI    = KW - 1;
  localparam int JI    = JW - 1;

  dense_state_t state_q;
  dense_state_t state_d;

  logic [KW-1:0] k_q;
  logic [JW-1:0] j_q;
  logic [KI-1:0] kx;
  logic [JI-1:0] jx;
  logic          k_last;
  logic          j_last;

  logic launch;
  logic mac_en;
  logic wr_en;
  logic fin_en;
  logic mac_clr;
  logic busy_q;
  logic done_q;

  logic signed [WIDTH-1:0] x_q   [IN_DIM];
  logic signed [WIDTH-1:0] out_q [OUT_DIM];
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] shifted;
  logic signed [WIDTH-1:0] wr_val;

  assign kx     = k_q[KI-1:0];
  assign jx     = j_q[JI-1:0];
  assign k_last = (k_q == KW'(IN_DIM - 1));
  assign j_last = (j_q == JW'(OUT_DIM - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (bus.start) state_d = MAC;
      MAC:    if (k_last) state_d = WRITE;
      WRITE: begin
        if (j_last) begin
`ifdef DENSE_MAX_SUB_EN
          state_d = MAXSUB;
`else
          state_d = FINISH;
`endif
        end else begin
          state_d = MAC;
        end
      end
      MAXSUB: if (j_last) state_d = FINISH;
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef DENSE_MAX_SUB_EN
  logic sub_en;
`endif

  always_comb begin
    launch = 1'b0;
    mac_en = 1'b0;
    wr_en  = 1'b0;
    fin_en = 1'b0;
`ifdef DENSE_MAX_SUB_EN
    sub_en = 1'b0;
`endif
    unique case (state_q)
      IDLE:   launch = bus.start;
      MAC:    mac_en = 1'b1;
      WRITE:  wr_en  = 1'b1;
`ifdef DENSE_MAX_SUB_EN
      MAXSUB: sub_en = 1'b1;
`endif
      FINISH: fin_en = 1'b1;
      default: ;
    endcase
  end

  assign mac_clr = launch | wr_en;

  dense_mac #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .a_i   (bus.weights[jx][kx]),
    .b_i   (x_q[kx]),
    .acc_o (acc)
  );

  // Bias is aligned to the product scale before the floor shift.
  always_comb begin
    sum     = acc + (ACC_W'(bus.bias[jx]) <<< FBITS);
    shifted = sum >>> FBITS;
    wr_val  = WIDTH'(sat_width(SAT_W'(shifted), WIDTH));
  end

`ifdef DENSE_MAX_SUB_EN
  logic signed [WIDTH-1:0] max_q;
  logic signed [WIDTH-1:0] sub_val;

  always_comb begin
    sub_val = WIDTH'(sat_width(SAT_W'(out_q[jx]) - SAT_W'(max_q), WIDTH));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max_q <= '0;
    end else if (wr_en && ((j_q == '0) || (wr_val > max_q))) begin
      max_q <= wr_val;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_q    <= '0;
      j_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      x_q    <= '{default: '0};
      out_q  <= '{default: '0};
    end else begin
      done_q <= fin_en;
      if (fin_en) busy_q <= 1'b0;
      if (launch) begin
        x_q    <= bus.input_data;
        k_q    <= '0;
        j_q    <= '0;
        busy_q <= 1'b1;
      end
      if (mac_en) k_q <= k_q + KW'(1);
      if (wr_en) begin
        out_q[jx] <= wr_val;
        k_q       <= '0;
        j_q       <= j_last ? '0 : j_q + JW'(1);
      end
`ifdef DENSE_MAX_SUB_EN
      if (sub_en) begin
        out_q[jx] <= sub_val;
        j_q       <= j_last ? '0 : j_q + JW'(1);
      end
`endif
    end
  end

  assign bus.output_data = out_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

`default_nettype wire

// File: tb/tb_dense_layer.sv
// ============================================================================
// tb_dense_layer : directed 2x2 vectors, handshake/reset sequences and a
// 16x10 random run against a reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dense_layer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

`ifdef DENSE_MAX_SUB_EN
  localparam int LAT_S = 9;
  localparam int LAT_B = 181;
`else
  localparam int LAT_S = 7;
  localparam int LAT_B = 171;
`endif

  dense_layer_if #(.WIDTH(16), .IN_DIM(2),  .OUT_DIM(2))  s_if ();
  dense_layer_if #(.WIDTH(16), .IN_DIM(16), .OUT_DIM(10)) b_if ();

  dense_layer #(.WIDTH(16), .FBITS(8), .IN_DIM(2), .OUT_DIM(2)) u_small (
    .clk   (clk),
    .reset (rst_n),
    .bus   (s_if)
  );

  dense_layer #(.WIDTH(16), .FBITS(8), .IN_DIM(16), .OUT_DIM(10)) u_big (
    .clk   (clk),
    .reset (rst_n),
    .bus   (b_if)
  );

  int n_vec   = 0;
  int n_err   = 0;
  int cyc     = 0;
  int n_done  = 0;
  int overlap = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (s_if.busy && s_if.done) overlap <= overlap + 1;
    if (s_if.done) n_done <= n_done + 1;
  end

  typedef struct {
    int x0, x1;
    int w00, w01, w10, w11;
    int b0, b1;
    int e0, e1;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int sat16(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  task automatic load_small(input vec_t v);
    s_if.input_data[0] = 16'(v.x0);
    s_if.input_data[1] = 16'(v.x1);
    s_if.weights[0][0] = 16'(v.w00);
    s_if.weights[0][1] = 16'(v.w01);
    s_if.weights[1][0] = 16'(v.w10);
    s_if.weights[1][1] = 16'(v.w11);
    s_if.bias[0]       = 16'(v.b0);
    s_if.bias[1]       = 16'(v.b1);
  endtask

  task automatic run_small(input vec_t v, input int id);
    int n;
    int e0;
    int e1;
    int mx;
    e0 = v.e0;
    e1 = v.e1;
    mx = (e0 > e1) ? e0 : e1;
`ifdef DENSE_MAX_SUB_EN
    e0 = sat16(longint'(e0 - mx));
    e1 = sat16(longint'(e1 - mx));
`endif
    @(negedge clk);
    load_small(v);
    s_if.start = 1'b1;
    @(posedge clk);
    #1;
    s_if.start = 1'b0;
    s_if.input_data[0] = 16'h5a5a;
    s_if.input_data[1] = 16'ha5a5;
    n = 0;
    while (!s_if.done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("v%0d latency (max %0d)", id, mx), n, LAT_S);
    check($sformatf("v%0d out0", id), int'(s_if.output_data[0]), e0);
    check($sformatf("v%0d out1", id), int'(s_if.output_data[1]), e1);
  endtask

  task automatic run_big(input int id);
    int     xs [16];
    int     ws [10][16];
    int     bs [10];
    int     ex [10];
    longint acc;
    int     mx;
    int     n;
    int     nbad;
    bit     full;
    full = (id % 4 == 0);
    for (int k = 0; k < 16; k++) begin
      xs[k] = full ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 2047)) - 1024;
    end
    for (int j = 0; j < 10; j++) begin
      bs[j] = int'($urandom_range(0, 65535)) - 32768;
      for (int k = 0; k < 16; k++) begin
        ws[j][k] = full ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 2047)) - 1024;
      end
    end
    mx = -32768;
    for (int j = 0; j < 10; j++) begin
      acc = longint'(bs[j]) * 256;
      for (int k = 0; k < 16; k++) acc += longint'(ws[j][k]) * longint'(xs[k]);
      ex[j] = sat16(acc >>> 8);
      if (ex[j] > mx) mx = ex[j];
    end
`ifdef DENSE_MAX_SUB_EN
    for (int j = 0; j < 10; j++) ex[j] = sat16(longint'(ex[j] - mx));
`endif
    @(negedge clk);
    for (int k = 0; k < 16; k++) b_if.input_data[k] = 16'(xs[k]);
    for (int j = 0; j < 10; j++) begin
      b_if.bias[j] = 16'(bs[j]);
      for (int k = 0; k < 16; k++) b_if.weights[j][k] = 16'(ws[j][k]);
    end
    b_if.start = 1'b1;
    @(posedge clk);
    #1;
    b_if.start = 1'b0;
    for (int k = 0; k < 16; k++) b_if.input_data[k] = 16'($urandom_range(0, 65535));
    n = 0;
    while (!b_if.done && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("rand%0d latency", id), n, LAT_B);
    nbad = 0;
    for (int j = 0; j < 10; j++) if (int'(b_if.output_data[j]) != ex[j]) nbad++;
    check($sformatf("rand%0d mismatching logits", id), nbad, 0);
  endtask

  initial begin
    int t0;
    int d0;
    int n;
    int nd;
    int td [3];

    tbl[0] = '{256, 512,     256, 0, 0, 256,                0, 0 + 128,      256, 640};
    tbl[1] = '{-256, 256,    256, 256, 512, -256,           0, 0,            0, -768};
    tbl[2] = '{-128, 0,      1, 0, 0, 0,                    0, 0,            -1, 0};
    tbl[3] = '{32767, 32767, 32767, 32767, -32767, -32767,  0, 0,            32767, -32768};
    tbl[4] = '{0, 0,         0, 0, 0, 0,                    32767, -32768,   32767, -32768};
    tbl[5] = '{3, 0,         100, 0, -100, 0,               0, 0,            1, -2};
    tbl[6] = '{512, -256,    384, 128, -128, -512,          -256, 1,         384, 257};

    rst_n       = 1'b0;
    s_if.start  = 1'b0;
    b_if.start  = 1'b0;
    s_if.input_data = '{default: '0};
    s_if.weights    = '{default: '{default: '0}};
    s_if.bias       = '{default: '0};
    b_if.input_data = '{default: '0};
    b_if.weights    = '{default: '{default: '0}};
    b_if.bias       = '{default: '0};

    repeat (3) @(negedge clk);
    check("reset busy", int'(s_if.busy), 0);
    check("reset done", int'(s_if.done), 0);
    check("reset out0", int'(s_if.output_data[0]), 0);
    check("reset out1", int'(s_if.output_data[1]), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_small(tbl[i], i);

    // Stray start pulses while busy and in the finishing cycle.
    @(negedge clk);
    load_small(tbl[0]);
    s_if.start = 1'b1;
    @(posedge clk);
    #1;
    s_if.start = 1'b0;
    d0 = n_done;
    check("busy after start", int'(s_if.busy), 1);
    @(posedge clk);
    #1;
    s_if.start = 1'b1;
    @(posedge clk);
    #1;
    s_if.start = 1'b0;
    repeat (LAT_S - 3) @(posedge clk);
    #1;
    s_if.start = 1'b1;
    @(posedge clk);
    #1;
    s_if.start = 1'b0;
    check("done at nominal latency", int'(s_if.done), 1);
    check("busy low with done", int'(s_if.busy), 0);
    repeat (12) @(posedge clk);
    #1;
    check("single done for stray starts", n_done - d0, 1);

    // Start held high: back-to-back runs.
    @(negedge clk);
    s_if.start = 1'b1;
    nd = 0;
    n  = 0;
    td = '{default: 0};
    while (nd < 3 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (s_if.done) begin
        td[nd] = cyc;
        nd++;
      end
    end
    s_if.start = 1'b0;
    check("held start done count", nd, 3);
    check("held start spacing 1", td[1] - td[0], LAT_S + 1);
    check("held start spacing 2", td[2] - td[1], LAT_S + 1);
    repeat (2) @(posedge clk);
    #1;
    check("idle after held start", int'(s_if.busy), 0);

    // Reset in the middle of a MAC phase.
    run_small(tbl[6], 16);
    @(negedge clk);
    load_small(tbl[0]);
    s_if.start = 1'b1;
    @(posedge clk);
    #1;
    s_if.start = 1'b0;
    d0 = n_done;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid reset busy", int'(s_if.busy), 0);
    check("mid reset done", int'(s_if.done), 0);
    check("mid reset out0", int'(s_if.output_data[0]), 0);
    check("mid reset out1", int'(s_if.output_data[1]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("no done after mid reset", n_done - d0, 0);
    run_small(tbl[0], 10);

    check("busy/done overlap cycles", overlap, 0);

    for (int r = 0; r < 200; r++) run_big(r);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
